fft_peak_bcd: RTL and testbench
===============================

Name: fft_peak_bcd

Overview:
- Upstream neighbour of the 7-segment display stage. Consumes the FFT output stream (Re/Im, one bin per en_comp strobe).
- Computes the squared magnitude of each bin from its top bits and tracks the bin with the largest magnitude.
- Presents that bin as a binary index and as 4 BCD digits for direct HEX display. Frame boundaries come from en_FFT (start) and done_all / bin count N (end).

Parameters:
- bit_width, 34, width of signed Re_in/Im_in.
- N, 32, bins per FFT frame.
- SIZE, 5, log2(N), width of binary bin index.
- MAG_BITS, 8, number of MSBs of Re/Im used for magnitude (signed).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- en_FFT  in  1  one-cycle pulse: new frame starts; clears search.
- en_comp  in  1  Re_in/Im_in valid this cycle (one bin).
- done_all  in  1  one-cycle pulse: frame ended early / externally.
- Re_in  in  bit_width  signed real part.
- Im_in  in  bit_width  signed imaginary part.
- busy  out  1  high in COLLECT or FLUSH.
- peak_valid  out  1  results valid; level, held until next en_FFT.
- peak_bin  out  SIZE  binary index of max bin.
- peak_bcd  out  16  4 BCD digits of peak_bin, [3:0] = units.
- peak_mag  out  2*MAG_BITS+1  unsigned max squared magnitude.

Behaviour:
- Reset: all outputs 0; state IDLE; bin counters 0.
- Stage 0 (accept, en_comp & COLLECT): re = Re_in[bit_width-1 -: MAG_BITS], im likewise. Bin index and BCD count tagged to the sample. Binary counter and BCD counter increment after each accepted sample.
- Stage 1 (t+1): mag = re*re + im*im, signed multiply with an unsigned 2*MAG_BITS+1 result. Max is (-128)^2*2 = 32768, which fits 17 bits; no saturation is needed.
- Stage 2 (t+2): if mag > max_mag (strict), update max_mag, peak_bin and peak_bcd. Ties keep the earliest bin.
- The search registers are internal; outputs are copied from them on entry to DONE.
- FSM states: IDLE, COLLECT, FLUSH, DONE.
  - IDLE -> COLLECT on en_FFT.
  - COLLECT -> FLUSH when the Nth sample is accepted or done_all is seen.
  - FLUSH lasts 2 cycles to drain the pipeline, then -> DONE.
  - DONE: peak_valid = 1; -> COLLECT on en_FFT.
- en_FFT in any state: clear max_mag and the counters, drop peak_valid, go to COLLECT. This includes restart mid-frame or mid-flush.
- en_FFT and en_comp in the same cycle: en_FFT wins; the sample is ignored.
- done_all and en_comp in the same cycle: the sample is accepted, then FLUSH.
- en_comp outside COLLECT is ignored; no sample beyond N is accepted.
- Empty frame (done_all with no samples): DONE with peak_bin=0, peak_bcd=0, peak_mag=0.
- All-zero frame: peak_bin = 0 (first bin, since comparison is strict).
- BCD counter: each digit wraps 9->0 with carry; 9999 wraps to 0000 (unreachable for N<=9999).
- Latency: Nth sample accepted at cycle t -> peak_valid high at t+3.

Optional Feature:
- Macro PEAK_SKIP_DC_EN.
- Defined: bin 0 is excluded from comparison (DC suppression). With all-zero or empty frames, peak_bin=0 and peak_mag=0 still hold.
- Undefined: every bin 0..N-1 competes.

Decomposition:
- Shared package fft_disp_pkg holds:
  - FSM state encodings (IDLE, COLLECT, FLUSH, DONE).
  - BCD digit width (4) and digit count (4).
  - Magnitude width function of MAG_BITS.
- Sub-module bcd_counter4: 4-digit cascaded BCD counter with sync clear, increment and 16-bit output. The same counter is reused by the display stage's timer.

Test Plan:
- Reset mid-COLLECT: assert rst_n=0 -> all outputs 0, busy=0, state IDLE immediately (asynchronous).
- Single peak: en_FFT, 32 bins with Re top byte = 0 except bin 13 = 8'sd100, Im = 8'sd50 -> peak_valid 3 cycles after bin 31; peak_bin=13, peak_bcd=16'h0013, peak_mag=12500.
- Tie and negative extremes: bins 4 and 20 both Re=-128, Im=-128 -> peak_bin=4, peak_mag=32768.
- Early end: 12 samples (peak at bin 11, value 1), then done_all -> peak_bin=11, peak_bcd=16'h0011. A 13th en_comp after done_all is ignored.
- Restart: en_FFT at bin 7 of a frame, then a full new frame with peak at bin 2 -> peak_bin=2; earlier data has no effect and peak_valid stays low until the new frame completes.
- PEAK_SKIP_DC_EN: bin 0 = (127,127), bin 5 = (10,0) -> with macro: peak_bin=5, mag=100; without macro: peak_bin=0, mag=32258.

Source files
------------

// File: rtl/fft_disp_pkg.sv
// Shared definitions for the FFT peak / display path.
//   - FSM state encoding for the peak search
//   - BCD digit geometry (digit width, digit count)
//   - mag_w(): width of an unsigned squared magnitude built from MAG_BITS-wide
//     signed Re/Im parts (sum of two squares needs one extra bit)
package fft_disp_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FLUSH   = 2'd2,
        DONE    = 2'd3
    } state_e;

    localparam int BCD_DIGIT_W = 4;
    localparam int BCD_DIGITS  = 4;

    function automatic int mag_w(input int mag_bits);
        return 2 * mag_bits + 1;
    endfunction

endpackage

// File: rtl/bcd_counter4.sv
// 4-digit cascaded BCD counter (also used by the display stage's timer).
// Ports:
//   clk     system clock
//   rst_n   asynchronous active-low reset, counter -> 0000
//   i_clr   synchronous clear, has priority over i_inc
//   i_inc   increment by one; each digit wraps 9->0 with carry, 9999 -> 0000
//   o_bcd   packed digits, [3:0] = units
module bcd_counter4
    import fft_disp_pkg::*;
(
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              i_clr,
    input  logic                              i_inc,
    output logic [BCD_DIGITS*BCD_DIGIT_W-1:0] o_bcd
);

    logic [BCD_DIGITS*BCD_DIGIT_W-1:0] r_bcd;
    logic [BCD_DIGITS*BCD_DIGIT_W-1:0] w_bcd_nxt;
    logic                              w_carry;

    // Ripple the carry from the units digit upward; a digit only advances
    // when every lower digit is rolling over from 9.
    always_comb begin
        w_bcd_nxt = r_bcd;
        w_carry   = i_inc;
        for (int d = 0; d < BCD_DIGITS; d++) begin
            if (w_carry) begin
                if (r_bcd[d*BCD_DIGIT_W +: BCD_DIGIT_W] == BCD_DIGIT_W'(9)) begin
                    w_bcd_nxt[d*BCD_DIGIT_W +: BCD_DIGIT_W] = '0;
                end else begin
                    w_bcd_nxt[d*BCD_DIGIT_W +: BCD_DIGIT_W] =
                        r_bcd[d*BCD_DIGIT_W +: BCD_DIGIT_W] + BCD_DIGIT_W'(1);
                    w_carry = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bcd <= '0;
        end else if (i_clr) begin
            r_bcd <= '0;
        end else begin
            r_bcd <= w_bcd_nxt;
        end
    end

    assign o_bcd = r_bcd;

endmodule

// File: rtl/fft_peak_bcd.sv
// FFT peak finder: squares the top MAG_BITS of each bin's Re/Im, keeps the
// bin with the strictly largest magnitude (earliest wins ties) and presents
// it as a binary index and as 4 BCD digits for the HEX display stage.
// Optional build macro: PEAK_SKIP_DC_EN -- when defined, bin 0 never competes.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   en_FFT              frame start pulse; clears the search from any state
//   en_comp             Re_in/Im_in hold one bin this cycle
//   done_all            external end-of-frame pulse
//   Re_in, Im_in        signed bin value, bit_width wide
//   busy                high in COLLECT or FLUSH
//   peak_valid          results valid, held until the next en_FFT
//   peak_bin/peak_bcd   index of the peak bin (binary / BCD, [3:0] = units)
//   peak_mag            unsigned squared magnitude of the peak
module fft_peak_bcd
    import fft_disp_pkg::*;
#(
    parameter int bit_width = 34,
    parameter int N         = 32,
    parameter int SIZE      = 5,
    parameter int MAG_BITS  = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              en_FFT,
    input  logic                              en_comp,
    input  logic                              done_all,
    input  logic signed [bit_width-1:0]       Re_in,
    input  logic signed [bit_width-1:0]       Im_in,
    output logic                              busy,
    output logic                              peak_valid,
    output logic [SIZE-1:0]                   peak_bin,
    output logic [BCD_DIGITS*BCD_DIGIT_W-1:0] peak_bcd,
    output logic [mag_w(MAG_BITS)-1:0]        peak_mag
);

    localparam int MW = mag_w(MAG_BITS);
    localparam int BW = BCD_DIGITS * BCD_DIGIT_W;

    // Squares are non-negative, so (-2^(M-1))^2 still fits a 2M-bit signed
    // product; the sum of two needs one more bit and never saturates.
    function automatic logic [MW-1:0] sq_mag(input logic signed [MAG_BITS-1:0] re,
                                             input logic signed [MAG_BITS-1:0] im);
        logic signed [2*MAG_BITS-1:0] re2;
        logic signed [2*MAG_BITS-1:0] im2;
        re2 = re * re;
        im2 = im * im;
        return {1'b0, re2} + {1'b0, im2};
    endfunction

    state_e                        r_state, w_state_nxt;
    logic                          r_flush_cnt;
    logic [SIZE-1:0]               r_cnt;
    logic [BW-1:0]                 w_bcd_cnt;
    logic                          w_accept, w_last, w_enter_done, w_cand;

    logic signed [MAG_BITS-1:0]    r_re_p1, r_im_p1;
    logic [SIZE-1:0]               r_bin_p1, r_bin_p2;
    logic [BW-1:0]                 r_bcd_p1, r_bcd_p2;
    logic [MW-1:0]                 r_mag_p2;
    logic                          r_vld_p1, r_vld_p2;

    logic [MW-1:0]                 r_max_mag, w_max_mag_nxt;
    logic [SIZE-1:0]               r_max_bin, w_max_bin_nxt;
    logic [BW-1:0]                 r_max_bcd, w_max_bcd_nxt;

    // Only the top MAG_BITS of each part feed the magnitude.
    logic w_unused;
    assign w_unused = ^{Re_in[bit_width-MAG_BITS-1:0], Im_in[bit_width-MAG_BITS-1:0]};

    // ---- Stage 0: accept a bin and tag it with its index ----
    assign w_accept = en_comp && (r_state == COLLECT) && !en_FFT;
    assign w_last   = w_accept && (r_cnt == SIZE'(N - 1));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = IDLE;
            COLLECT: if (done_all || w_last) w_state_nxt = FLUSH;
            FLUSH:   if (r_flush_cnt) w_state_nxt = DONE;
            DONE:    w_state_nxt = DONE;
            default: w_state_nxt = IDLE;
        endcase
        if (en_FFT) w_state_nxt = COLLECT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_flush_cnt <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= (r_state == FLUSH) && (w_state_nxt == FLUSH);
            if (en_FFT)        r_cnt <= '0;
            else if (w_accept) r_cnt <= r_cnt + SIZE'(1);
        end
    end

    bcd_counter4 u_bcd_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (en_FFT),
        .i_inc (w_accept),
        .o_bcd (w_bcd_cnt)
    );

    assign busy = (r_state == COLLECT) || (r_state == FLUSH);

    always_ff @(posedge clk) begin
        r_re_p1  <= $signed(Re_in[bit_width-1 -: MAG_BITS]);
        r_im_p1  <= $signed(Im_in[bit_width-1 -: MAG_BITS]);
        r_bin_p1 <= r_cnt;
        r_bcd_p1 <= w_bcd_cnt;
    end

    // ---- Stage 1: squared magnitude ----
    always_ff @(posedge clk) begin
        r_mag_p2 <= sq_mag(r_re_p1, r_im_p1);
        r_bin_p2 <= r_bin_p1;
        r_bcd_p2 <= r_bcd_p1;
    end

    // A restart invalidates anything still in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p1 <= 1'b0;
            r_vld_p2 <= 1'b0;
        end else begin
            r_vld_p1 <= w_accept;
            r_vld_p2 <= r_vld_p1 && !en_FFT;
        end
    end

    // ---- Stage 2: strict-greater compare against the running maximum ----
`ifdef PEAK_SKIP_DC_EN
    assign w_cand = r_vld_p2 && (r_bin_p2 != '0) && (r_mag_p2 > r_max_mag);
`else
    assign w_cand = r_vld_p2 && (r_mag_p2 > r_max_mag);
`endif

    always_comb begin
        w_max_mag_nxt = r_max_mag;
        w_max_bin_nxt = r_max_bin;
        w_max_bcd_nxt = r_max_bcd;
        if (en_FFT) begin
            w_max_mag_nxt = '0;
            w_max_bin_nxt = '0;
            w_max_bcd_nxt = '0;
        end else if (w_cand) begin
            w_max_mag_nxt = r_mag_p2;
            w_max_bin_nxt = r_bin_p2;
            w_max_bcd_nxt = r_bcd_p2;
        end
    end

    // The last bin's compare lands on the same edge that enters DONE, so the
    // outputs are loaded from the next-state search values.
    assign w_enter_done = (r_state == FLUSH) && (w_state_nxt == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_max_mag  <= '0;
            r_max_bin  <= '0;
            r_max_bcd  <= '0;
            peak_valid <= 1'b0;
            peak_bin   <= '0;
            peak_bcd   <= '0;
            peak_mag   <= '0;
        end else begin
            r_max_mag <= w_max_mag_nxt;
            r_max_bin <= w_max_bin_nxt;
            r_max_bcd <= w_max_bcd_nxt;
            if (en_FFT) begin
                peak_valid <= 1'b0;
            end else if (w_enter_done) begin
                peak_valid <= 1'b1;
                peak_bin   <= w_max_bin_nxt;
                peak_bcd   <= w_max_bcd_nxt;
                peak_mag   <= w_max_mag_nxt;
            end
        end
    end

endmodule

// File: tb/tb_fft_peak_bcd.sv
module tb_fft_peak_bcd;

    localparam int BW = 34;
    localparam int NB = 32;
    localparam int SZ = 5;
    localparam int MB = 8;
    localparam int MW = 2 * MB + 1;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 en_FFT = 1'b0;
    logic                 en_comp = 1'b0;
    logic                 done_all = 1'b0;
    logic signed [BW-1:0] Re_in = '0;
    logic signed [BW-1:0] Im_in = '0;
    logic                 busy;
    logic                 peak_valid;
    logic [SZ-1:0]        peak_bin;
    logic [15:0]          peak_bcd;
    logic [MW-1:0]        peak_mag;

    always #5 clk = ~clk;

    fft_peak_bcd #(.bit_width(BW), .N(NB), .SIZE(SZ), .MAG_BITS(MB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_FFT     (en_FFT),
        .en_comp    (en_comp),
        .done_all   (done_all),
        .Re_in      (Re_in),
        .Im_in      (Im_in),
        .busy       (busy),
        .peak_valid (peak_valid),
        .peak_bin   (peak_bin),
        .peak_bcd   (peak_bcd),
        .peak_mag   (peak_mag)
    );

    typedef struct {
        int          bin;
        logic [15:0] bcd;
        int          mag;
    } exp_t;

    typedef struct {
        string nm;
        int    pk;
        int    re;
        int    im;
        int    eb;
        int    em;
    } vec_t;

    exp_t              sb[$];
    vec_t              tbl[6];
    int                errors = 0;
    int                checks = 0;
    logic signed [7:0] f_re[NB];
    logic signed [7:0] f_im[NB];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic clear_frame();
        for (int i = 0; i < NB; i++) begin
            f_re[i] = '0;
            f_im[i] = '0;
        end
    endtask

    // Low bits are random junk: only the top byte may affect the result.
    task automatic set_bin(input int i);
        Re_in = {f_re[i], (BW-MB)'($urandom)};
        Im_in = {f_im[i], (BW-MB)'($urandom)};
    endtask

    task automatic start_frame();
        en_FFT = 1'b1;
        tick();
        en_FFT = 1'b0;
    endtask

    task automatic send(input int n);
        for (int i = 0; i < n; i++) begin
            set_bin(i);
            en_comp = 1'b1;
            tick();
        end
        en_comp = 1'b0;
    endtask

    task automatic wait_result(input string nm);
        exp_t e;
        int   k;
        k = 0;
        while (!peak_valid && k < 20) begin
            tick();
            k++;
        end
        check({nm, "_valid"}, 32'(peak_valid), 32'd1);
        if (sb.size() == 0) begin
            check({nm, "_sb_nonempty"}, 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            check({nm, "_bin"}, 32'(peak_bin), 32'(e.bin));
            check({nm, "_bcd"}, 32'(peak_bcd), 32'(e.bcd));
            check({nm, "_mag"}, 32'(peak_mag), 32'(e.mag));
        end
    endtask

    // Full 32-bin frame with exact latency check: valid exactly 3 cycles
    // after the cycle carrying the last bin.
    task automatic run_full(input string nm);
        start_frame();
        check({nm, "_valid_dropped"}, 32'(peak_valid), 32'd0);
        check({nm, "_busy"}, 32'(busy), 32'd1);
        send(NB);
        check({nm, "_lat_t1"}, 32'(peak_valid), 32'd0);
        tick();
        check({nm, "_lat_t2"}, 32'(peak_valid), 32'd0);
        tick();
        check({nm, "_lat_t3"}, 32'(peak_valid), 32'd1);
        wait_result(nm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{"single13", 13, 100, 50, 13, 12500};
        tbl[1] = '{"neg31", 31, -128, 127, 31, 32513};
        tbl[2] = '{"mid9", 9, 0, -7, 9, 49};
        tbl[3] = '{"carry10", 10, 3, 4, 10, 25};
        tbl[4] = '{"bin20", 20, 127, 0, 20, 16129};
`ifdef PEAK_SKIP_DC_EN
        tbl[5] = '{"dc_only", 0, -1, 0, 0, 0};
`else
        tbl[5] = '{"dc_only", 0, -1, 0, 0, 1};
`endif

        // Reset state, with en_comp wiggling in IDLE
        tick();
        en_comp = 1'b1;
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(peak_valid), 32'd0);
        check("rst_bin", 32'(peak_bin), 32'd0);
        check("rst_bcd", 32'(peak_bcd), 32'd0);
        check("rst_mag", 32'(peak_mag), 32'd0);
        rst_n = 1'b1;
        tick();
        tick();
        en_comp = 1'b0;
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_valid", 32'(peak_valid), 32'd0);

        // Table-driven single-peak frames
        for (int v = 0; v < 6; v++) begin
            clear_frame();
            f_re[tbl[v].pk] = 8'(tbl[v].re);
            f_im[tbl[v].pk] = 8'(tbl[v].im);
            sb.push_back('{tbl[v].eb, to_bcd(tbl[v].eb), tbl[v].em});
            run_full(tbl[v].nm);
        end

        // Tie of negative extremes: earliest bin wins
        clear_frame();
        for (int i = 0; i < NB; i++) f_re[i] = 8'sd1;
        f_re[4] = -8'sd128;  f_im[4] = -8'sd128;
        f_re[20] = -8'sd128; f_im[20] = -8'sd128;
        sb.push_back('{4, 16'h0004, 32768});
        run_full("tie");

        // All-zero frame
        clear_frame();
        sb.push_back('{0, 16'h0000, 0});
        run_full("allzero");

        // Early end: 12 bins then done_all, 13th en_comp must be ignored
        clear_frame();
        f_re[11] = 8'sd1;
        f_re[12] = 8'sd127;
        sb.push_back('{11, 16'h0011, 1});
        start_frame();
        send(12);
        done_all = 1'b1;
        tick();
        done_all = 1'b0;
        set_bin(12);
        en_comp = 1'b1;
        tick();
        en_comp = 1'b0;
        check("early_lat_t2", 32'(peak_valid), 32'd0);
        tick();
        check("early_lat_t3", 32'(peak_valid), 32'd1);
        wait_result("early");
        check("early_busy_done", 32'(busy), 32'd0);

        // Empty frame
        start_frame();
        done_all = 1'b1;
        tick();
        done_all = 1'b0;
        sb.push_back('{0, 16'h0000, 0});
        wait_result("empty");

        // Restart at bin 7 (en_FFT together with en_comp), then a new frame
        clear_frame();
        f_re[5] = -8'sd128;
        f_im[5] = -8'sd128;
        start_frame();
        send(7);
        set_bin(7);
        en_FFT = 1'b1;
        en_comp = 1'b1;
        tick();
        en_FFT = 1'b0;
        en_comp = 1'b0;
        check("restart_valid_low", 32'(peak_valid), 32'd0);
        check("restart_busy", 32'(busy), 32'd1);
        clear_frame();
        f_re[2] = 8'sd50;
        f_im[2] = -8'sd20;
        send(16);
        check("restart_mid_valid", 32'(peak_valid), 32'd0);
        for (int i = 16; i < NB; i++) begin
            set_bin(i);
            en_comp = 1'b1;
            tick();
        end
        en_comp = 1'b0;
        check("restart_t1_valid", 32'(peak_valid), 32'd0);
        sb.push_back('{2, 16'h0002, 2900});
        wait_result("restart");

        // DC suppression case
        clear_frame();
        f_re[0] = 8'sd127;
        f_im[0] = 8'sd127;
        f_re[5] = 8'sd10;
`ifdef PEAK_SKIP_DC_EN
        sb.push_back('{5, 16'h0005, 100});
`else
        sb.push_back('{0, 16'h0000, 32258});
`endif
        run_full("dc");

        // Asynchronous reset mid-COLLECT
        clear_frame();
        start_frame();
        send(5);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_valid", 32'(peak_valid), 32'd0);
        check("arst_bin", 32'(peak_bin), 32'd0);
        check("arst_bcd", 32'(peak_bcd), 32'd0);
        check("arst_mag", 32'(peak_mag), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("arst_idle_busy", 32'(busy), 32'd0);

        // Fresh frame after reset: counters restarted from 0
        clear_frame();
        f_re[3] = 8'sd2;
        sb.push_back('{3, 16'h0003, 4});
        run_full("post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
